// File: rtl/packer_activations_pkg.sv
// Shared types and constants for the activation packer and the read-side unpacking driver.
// The word_strb field exists only when PACKER_ACTIVATIONS_WSTRB_EN is defined.
package packer_activations_pkg;

  localparam int unsigned IO_DATA_WIDTH = 8;
  localparam int unsigned MEM_BW        = 128;
  localparam int unsigned ADDR_WIDTH    = 16;
  localparam int unsigned LANES         = MEM_BW / IO_DATA_WIDTH;
  localparam int unsigned LANE_IDX_W    = $clog2(LANES);
  localparam int unsigned STATE_W       = 2;

  typedef logic [IO_DATA_WIDTH-1:0] act_t;
  typedef logic [MEM_BW-1:0]        word_t;
  typedef logic [LANE_IDX_W-1:0]    lane_idx_t;
  typedef logic [ADDR_WIDTH-1:0]    addr_t;
  typedef logic [LANES-1:0]         strb_t;
  typedef logic [STATE_W-1:0]       state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_FILL  = 2'd1;
  localparam state_t ST_DRAIN = 2'd2;
  localparam state_t ST_DONE  = 2'd3;

  // Payload carried by the output holding register toward the activation memory.
  typedef struct packed {
    addr_t addr;
    word_t data;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
    strb_t strb;
`endif
  } out_word_t;

endpackage

// File: rtl/packer_output_stage.sv
// Single-entry holding register for a packed word and its address, valid/ready toward memory.
// free_c is high when a new word may be loaded on this edge (empty, or handing off now).
module packer_output_stage
  import packer_activations_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      load_i,
  input  out_word_t data_i,
  output logic      free_c,
  output logic      valid_o,
  output out_word_t data_o,
  input  logic      ready_i
);

  logic      valid_q, valid_d;
  out_word_t data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign free_c  = !valid_q || ready_i;
  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/packer_activations.sv
// Activation packer: packs one activation per cycle into MEM_BW-bit words, lane 0 at the MSBs.
// Optional word_strb output is enabled by PACKER_ACTIVATIONS_WSTRB_EN.
module packer_activations
  import packer_activations_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDR_WIDTH-1:0]    base_addr,
  input  logic [IO_DATA_WIDTH-1:0] act_in,
  input  logic                     act_valid,
  input  logic                     act_last,
  output logic                     act_ready,
  output logic [MEM_BW-1:0]        word_out,
  output logic [ADDR_WIDTH-1:0]    word_addr,
  output logic                     word_valid,
  input  logic                     word_ready,
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
  output logic [LANES-1:0]         word_strb,
`endif
  output logic                     busy,
  output logic                     done
);

  state_t      state_q, state_d;
  lane_idx_t   lane_q, lane_d;
  word_t       fill_q, fill_d;
  logic        pending_q, pending_d;
  addr_t       next_addr_q, next_addr_d;
  logic        accept, complete, out_free, load;
  word_t       built;
  int unsigned lane_pos;
  out_word_t   load_data, out_data;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
  strb_t       fill_strb_q, fill_strb_d, built_strb;
`endif

  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    fill_d      = fill_q;
    pending_d   = pending_q;
    next_addr_d = next_addr_q;
    load        = 1'b0;
    load_data   = '0;
    built       = '0;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
    fill_strb_d = fill_strb_q;
    built_strb  = '0;
`endif
    lane_pos  = LANES - 1 - 32'(lane_q);
    act_ready = (state_q == ST_FILL) && !(pending_q && !out_free);
    accept    = act_valid && act_ready;
    complete  = accept && (act_last || (lane_q == lane_idx_t'(LANES - 1)));

    // A completed word held in the fill register leaves as soon as the output frees.
    if (pending_q && out_free) begin
      load           = 1'b1;
      load_data.addr = next_addr_q;
      load_data.data = fill_q;
      next_addr_d    = next_addr_q + addr_t'(1);
      fill_d         = '0;
      pending_d      = 1'b0;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
      load_data.strb = fill_strb_q;
      fill_strb_d    = '0;
`endif
    end

    if (accept) begin
      built = fill_d | (word_t'(act_in) << (IO_DATA_WIDTH * lane_pos));
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
      built_strb = fill_strb_d | (strb_t'(1) << lane_pos);
`endif
      if (complete) begin
        lane_d = '0;
        if (out_free && !pending_q) begin
          load           = 1'b1;
          load_data.addr = next_addr_q;
          load_data.data = built;
          next_addr_d    = next_addr_q + addr_t'(1);
          fill_d         = '0;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
          load_data.strb = built_strb;
          fill_strb_d    = '0;
`endif
        end else begin
          pending_d = 1'b1;
          fill_d    = built;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
          fill_strb_d = built_strb;
`endif
        end
      end else begin
        lane_d = lane_q + lane_idx_t'(1);
        fill_d = built;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
        fill_strb_d = built_strb;
`endif
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d     = ST_FILL;
          next_addr_d = base_addr;
          lane_d      = '0;
          fill_d      = '0;
          pending_d   = 1'b0;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
          fill_strb_d = '0;
`endif
        end
      end
      ST_FILL:  if (accept && act_last) state_d = ST_DRAIN;
      ST_DRAIN: if (!pending_q && word_valid && word_ready) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      lane_q      <= '0;
      fill_q      <= '0;
      pending_q   <= 1'b0;
      next_addr_q <= '0;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
      fill_strb_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      fill_q      <= fill_d;
      pending_q   <= pending_d;
      next_addr_q <= next_addr_d;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
      fill_strb_q <= fill_strb_d;
`endif
    end
  end

  packer_output_stage u_out (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .data_i  (load_data),
    .free_c  (out_free),
    .valid_o (word_valid),
    .data_o  (out_data),
    .ready_i (word_ready)
  );

  assign word_out  = out_data.data;
  assign word_addr = out_data.addr;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
  assign word_strb = out_data.strb;
`endif
  assign busy = (state_q != ST_IDLE);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_packer_activations.sv
// Directed bench for packer_activations with a tensor-level reference model checked every cycle.
module tb_packer_activations;
  import packer_activations_pkg::*;

  logic  clk = 1'b0;
  logic  rst, start, act_valid, act_last, act_ready;
  logic  word_valid, word_ready, busy, done;
  addr_t base_addr, word_addr;
  act_t  act_in;
  word_t word_out;
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
  strb_t word_strb;
`endif

  packer_activations dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .base_addr  (base_addr),
    .act_in     (act_in),
    .act_valid  (act_valid),
    .act_last   (act_last),
    .act_ready  (act_ready),
    .word_out   (word_out),
    .word_addr  (word_addr),
    .word_valid (word_valid),
    .word_ready (word_ready),
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
    .word_strb  (word_strb),
`endif
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chkw(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: accepted activations grouped into words, words queued until handed off.
  typedef struct {
    word_t w;
    addr_t a;
    strb_t s;
  } exp_t;

  exp_t  expq[$];
  act_t  cur[$];
  bit    m_fill, m_drain, m_done;
  addr_t m_addr;
  int    t_acc, t_hs;

  always @(negedge clk) begin
    int    q;
    bit    hs, busy_now;
    exp_t  e;
    q        = expq.size();
    hs       = (q > 0) && word_ready;
    busy_now = m_fill || m_drain || m_done;
    chk1("done", done, m_done);
    chk1("busy", busy, busy_now);
    chk1("word_valid", word_valid, q > 0);
    chk1("act_ready", act_ready, m_fill && !(q >= 2 && !hs));
    if (q > 0) begin
      chkw("word_out", word_out, expq[0].w);
      chkw("word_addr", 128'(word_addr), 128'(expq[0].a));
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
      chkw("word_strb", 128'(word_strb), 128'(expq[0].s));
`endif
    end
    m_done = 1'b0;
    if (hs) begin
      void'(expq.pop_front());
      t_hs++;
      if (m_drain && expq.size() == 0) begin
        m_drain = 1'b0;
        m_done  = 1'b1;
      end
    end
    if (act_valid && act_ready) begin
      cur.push_back(act_in);
      t_acc++;
      if (cur.size() == LANES || act_last) begin
        e.w = '0;
        e.s = '0;
        for (int i = 0; i < LANES; i++) begin
          e.w = {e.w[MEM_BW-IO_DATA_WIDTH-1:0], (i < cur.size()) ? cur[i] : act_t'(0)};
          e.s = {e.s[LANES-2:0], 1'(i < cur.size())};
        end
        e.a    = m_addr;
        m_addr = m_addr + addr_t'(1);
        expq.push_back(e);
        cur.delete();
      end
      if (act_last) begin
        m_fill  = 1'b0;
        m_drain = 1'b1;
      end
    end
    if (start && !busy_now) begin
      m_fill = 1'b1;
      m_addr = base_addr;
      cur.delete();
      t_acc = 0;
      t_hs  = 0;
    end
    if (rst) begin
      m_fill  = 1'b0;
      m_drain = 1'b0;
      m_done  = 1'b0;
      expq.delete();
      cur.delete();
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input addr_t b);
    start     = 1'b1;
    base_addr = b;
    sync();
    start = 1'b0;
  endtask

  task automatic push(input act_t d, input logic last);
    bit ok = 1'b0;
    act_in    = d;
    act_valid = 1'b1;
    act_last  = last;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (act_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("push_accepted", ok, 1'b1);
    sync();
    act_valid = 1'b0;
    act_last  = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    chk1("done_seen", seen, 1'b1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk1({tag, "_act_ready"}, act_ready, 1'b0);
    chk1({tag, "_word_valid"}, word_valid, 1'b0);
    chkw({tag, "_word_out"}, word_out, '0);
    chkw({tag, "_word_addr"}, 128'(word_addr), '0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; act_in = '0;
    act_valid = 1'b0; act_last = 1'b0; word_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_values("reset");
    sync();
    rst = 1'b0;

    // Full word, 16 lanes, last on lane 15
    do_start(16'h0010);
    for (int i = 0; i < 16; i++) push(act_t'(i), i == 15);
    @(negedge clk);
    chk1("full_valid", word_valid, 1'b1);
    chkw("full_word", word_out, 128'h00010203_04050607_08090A0B_0C0D0E0F);
    chkw("full_addr", 128'(word_addr), 128'h0010);
    @(negedge clk);
    chk1("full_done", done, 1'b1);
    sync();

    // Partial word, zero padded
    do_start(16'h0020);
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b1);
    @(negedge clk);
    chkw("partial_word", word_out, 128'hA1A2A300_00000000_00000000_00000000);
    chkw("partial_addr", 128'(word_addr), 128'h0020);
`ifdef PACKER_ACTIVATIONS_WSTRB_EN
    chkw("partial_strb", 128'(word_strb), 128'hE000);
`endif
    wait_done();
    sync();

    // Backpressure: memory stalled for about 40 cycles
    word_ready = 1'b0;
    do_start(16'h0100);
    fork
      for (int i = 0; i < 48; i++) push(act_t'(i), i == 47);
      begin
        repeat (38) @(negedge clk);
        chkw("bp_accepts", 128'(t_acc), 128'd32);
        chk1("bp_act_ready", act_ready, 1'b0);
        chk1("bp_hold_valid", word_valid, 1'b1);
        chkw("bp_hold_addr", 128'(word_addr), 128'h0100);
        sync();
        sync();
        word_ready = 1'b1;
      end
    join
    wait_done();
    chkw("bp_words", 128'(t_hs), 128'd3);
    sync();

    // Address wrap
    do_start(16'hFFFF);
    for (int i = 0; i < 32; i++) begin
      push(act_t'(64 + i), i == 31);
      if (i == 15 || i == 31) begin
        @(negedge clk);
        chkw("wrap_addr", 128'(word_addr), (i == 15) ? 128'hFFFF : 128'h0000);
        sync();
      end
    end
    wait_done();
    sync();

    // Reset mid-operation with a word held and a partial fill
    word_ready = 1'b0;
    do_start(16'h0200);
    for (int i = 0; i < 21; i++) push(act_t'(128 + i), 1'b0);
    rst = 1'b1;
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_values("midrst");
    sync();
    word_ready = 1'b1;
    do_start(16'h0300);
    push(8'h55, 1'b0);
    push(8'h66, 1'b1);
    @(negedge clk);
    chkw("restart_word", word_out, 128'h55660000_00000000_00000000_00000000);
    chkw("restart_addr", 128'(word_addr), 128'h0300);
    wait_done();
    sync();

    // Start while busy is ignored; last on lane 15 yields exactly one word
    do_start(16'h0400);
    for (int i = 0; i < 8; i++) push(act_t'(16 + i), 1'b0);
    do_start(16'h0777);
    for (int i = 8; i < 16; i++) push(act_t'(16 + i), i == 15);
    @(negedge clk);
    chkw("corner_word", word_out, 128'h10111213_14151617_18191A1B_1C1D1E1F);
    chkw("corner_addr", 128'(word_addr), 128'h0400);
    wait_done();
    chkw("corner_words", 128'(t_hs), 128'd1);
    repeat (5) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
